// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings and
// the handshake constants used between the ALU and the divider.
package iter_divider_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'd0,
        DIV_BY_ZERO = 2'd1,
        DIV_ON      = 2'd2,
        DIV_END     = 2'd3
    } div_state_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negation of a WIDTH-bit word; used for
// operand magnitudes and for the quotient/remainder sign fix-up.
module div_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic             neg_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg_en ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/iter_divider.sv
// Radix-2 restoring divider answering the ALU start/cancel/ready handshake.
// One quotient bit per clock; result is {remainder, quotient}.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    div_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               sgn_q;
    logic               a_neg_q;
    logic               b_neg_q;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   fix_q;
    logic [WIDTH-1:0]   fix_r;
    logic [WIDTH:0]     shifted;
    logic signed [WIDTH:0] diff;

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_a (
        .neg_en (signed_div_i & opdata1_i[WIDTH-1]),
        .din    (opdata1_i),
        .dout   (abs_a)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_b (
        .neg_en (signed_div_i & opdata2_i[WIDTH-1]),
        .din    (opdata2_i),
        .dout   (abs_b)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_fix_q (
        .neg_en (sgn_q & (a_neg_q ^ b_neg_q)),
        .din    (quo_q),
        .dout   (fix_q)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_fix_r (
        .neg_en (sgn_q & a_neg_q),
        .din    (rem_q),
        .dout   (fix_r)
    );

    // The partial remainder stays below the divisor, so the true difference
    // always fits in WIDTH+1 signed bits and the MSB is a valid sign.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = $signed(shifted) - $signed({1'b0, dvs_q});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sgn_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else if (annul_i) begin
            state   <= DIV_FREE;
            cnt     <= '0;
            ready_o <= DIV_RESULT_NOT_READY;
        end else begin
            case (state)
                DIV_FREE: begin
                    ready_o <= DIV_RESULT_NOT_READY;
                    if (start_i == DIV_START) begin
                        sgn_q   <= signed_div_i;
                        a_neg_q <= opdata1_i[WIDTH-1];
                        b_neg_q <= opdata2_i[WIDTH-1];
                        rem_q   <= '0;
                        quo_q   <= abs_a;
                        dvs_q   <= abs_b;
                        cnt     <= '0;
                        state   <= (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                    end
                end
                DIV_BY_ZERO: begin
                    // Zeroed magnitudes with sign fix-up disabled give an all-zero result.
                    rem_q <= '0;
                    quo_q <= '0;
                    sgn_q <= 1'b0;
                    state <= DIV_END;
                end
                DIV_ON: begin
                    if (!diff[WIDTH]) begin
                        rem_q <= diff[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= shifted[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DIV_END;
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        state   <= DIV_FREE;
                        ready_o <= DIV_RESULT_NOT_READY;
                    end else begin
                        result_o <= {fix_r, fix_q};
                        ready_o  <= DIV_RESULT_READY;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: arithmetic reference model plus directed and
// randomized divide operations over the start/annul/ready handshake.
module tb_iter_divider;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           signed_div_i = 1'b0;
    logic [W-1:0]   opdata1_i = '0;
    logic [W-1:0]   opdata2_i = '0;
    logic           start_i = 1'b0;
    logic           annul_i = 1'b0;
    logic [2*W-1:0] result_o;
    logic           ready_o;

    int checks   = 0;
    int failures = 0;

    iter_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_div(input logic s, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint sa, sb, q, r;
        if (b == '0) return '0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[W-1:0], q[W-1:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic check64(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Protocol-level model: idle / busy(countdown) / done
    int             m_ph;
    int             m_cd;
    logic           m_ready;
    logic [2*W-1:0] m_result;
    logic [2*W-1:0] m_pend;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph = 0; m_cd = 0; m_ready = 1'b0; m_result = '0; m_pend = '0;
        end else if (annul_i) begin
            m_ph = 0; m_ready = 1'b0;
        end else begin
            case (m_ph)
                0: if (start_i) begin
                    m_pend = ref_div(signed_div_i, opdata1_i, opdata2_i);
                    m_cd   = (opdata2_i == '0) ? 2 : W + 1;
                    m_ph   = 1;
                end
                1: begin
                    m_cd--;
                    if (m_cd == 0) begin
                        m_ready  = 1'b1;
                        m_result = m_pend;
                        m_ph     = 2;
                    end
                end
                default: if (!start_i) begin
                    m_ready = 1'b0;
                    m_ph    = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (ready_o !== m_ready) begin
                failures++;
                $display("FAIL cyc_ready actual=%b expected=%b t=%0t", ready_o, m_ready, $time);
            end
            checks++;
            if (result_o !== m_result) begin
                failures++;
                $display("FAIL cyc_result actual=%h expected=%h t=%0t", result_o, m_result, $time);
            end
        end
    end

    // Runs one operation; returns the cycle count from the accepting edge to ready.
    task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int n, output logic [2*W-1:0] res);
        @(negedge clk);
        signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        @(posedge clk);
        n = 0;
        forever begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) begin
                opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = $urandom_range(0, 1);
            end
            if (ready_o) break;
            if (n > 100) begin
                failures++;
                $display("FAIL op_timeout actual=no_ready expected=ready");
                break;
            end
        end
        res = result_o;
        repeat (2) @(posedge clk);
        #1;
        check64("hold_result", result_o, res);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check_int("drop_to_idle_ready", int'(ready_o), 0);
    endtask

    initial begin
        int n;
        logic [2*W-1:0] res;
        logic [W-1:0] a, b;
        logic s;
        bit rose;

        check64("model_neg7_2", ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        check64("model_ovf", ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        check64("model_u_ffff", ref_div(1'b0, 32'hFFFF_FFFF, 32'h10), 64'h0000_000F_0FFF_FFFF);

        #12;
        check_int("reset_ready", int'(ready_o), 0);
        check64("reset_result", result_o, '0);
        @(negedge clk);
        rst = 1'b1;

        do_op(1'b0, 32'd7, 32'd2, n, res);
        check_int("lat_7_2", n, 33);
        check64("res_7_2", res, 64'h0000_0001_0000_0003);

        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, n, res);
        check64("res_neg7_2", res, 64'hFFFF_FFFF_FFFF_FFFD);

        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, n, res);
        check64("res_ovf", res, 64'h0000_0000_8000_0000);

        do_op(1'b0, 32'hFFFF_FFFF, 32'h10, n, res);
        check64("res_u_ffff_10", res, 64'h0000_000F_0FFF_FFFF);

        do_op(1'b0, 32'h1234, 32'h0, n, res);
        check_int("lat_divzero", n, 2);
        check64("res_divzero", res, 64'h0);

        // Cancel at iteration 10; ready must never rise
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        rose = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) rose = 1'b1;
        end
        check_int("annul_no_ready", int'(rose), 0);

        // Cancel together with start in idle must not launch an operation
        @(negedge clk);
        opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        rose = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) rose = 1'b1;
        end
        check_int("annul_prio_no_ready", int'(rose), 0);

        do_op(1'b0, 32'd100, 32'd7, n, res);
        check_int("lat_100_7", n, 33);
        check64("res_100_7", res, 64'h0000_0002_0000_000E);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd12345; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (21) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_int("async_rst_ready", int'(ready_o), 0);
        check64("async_rst_result", result_o, '0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        do_op(1'b0, 32'd9, 32'd3, n, res);
        check64("res_9_3", res, 64'h0000_0000_0000_0003);

        for (int i = 0; i < 40; i++) begin
            s = $urandom_range(0, 1);
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            do_op(s, a, b, n, res);
            check_int("rand_lat", n, (b == '0) ? 2 : W + 1);
            check64("rand_res", res, ref_div(s, a, b));
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
